// File: rtl/pqr5_core_pkg.sv
// Shared constants and types for the pqr5 core data-memory responder.
// Defines `XLEN (default 32) when the build does not supply it.
// Optional feature macro used by dmem_resp_unit: DMEM_MISALIGN_CHK_EN.
`ifndef XLEN
`define XLEN 32
`endif

package pqr5_core_pkg;

    localparam int XLEN = `XLEN;

    // Access size encodings (3 is treated as WORD)
    localparam logic [1:0] BYTE  = 2'd0;
    localparam logic [1:0] HWORD = 2'd1;
    localparam logic [1:0] WORD  = 2'd2;

    // Command encodings
    localparam logic LOAD  = 1'b0;
    localparam logic STORE = 1'b1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        WAIT   = 2'd2
    } dmem_resp_state_e;

    // HWORD on an odd byte, or WORD (and size 3) off a word boundary
    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] off);
        logic res;
        case (size)
            BYTE:    res = 1'b0;
            HWORD:   res = off[0];
            default: res = (off != 2'b00);
        endcase
        return res;
    endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// Byte-lane helper: byte enables for an incoming command and
// right-aligned, zero-extended extraction of RAM read data.
module dmem_lane_align
    import pqr5_core_pkg::*;
(
    input  logic [1:0]        i_cmd_size,
    input  logic [1:0]        i_cmd_off,
    input  logic [1:0]        i_rsp_size,
    input  logic [1:0]        i_rsp_off,
    input  logic [`XLEN-1:0]  i_rdata,
    output logic [3:0]        o_be,
    output logic [`XLEN-1:0]  o_rdata
);

    logic [`XLEN-1:0] w_sh;

    // Byte enables; HWORD at offset 3 truncates to the top lane only
    always_comb begin
        o_be = 4'b1111;
        case (i_cmd_size)
            BYTE:    o_be = 4'b0001 << i_cmd_off;
            HWORD:   o_be = 4'b0011 << i_cmd_off;
            default: o_be = 4'b1111;
        endcase
    end

    // Read extract: shift the addressed lane down, zero-extend; WORD is unshifted
    always_comb begin
        w_sh    = i_rdata >> {i_rsp_off, 3'b000};
        o_rdata = i_rdata;
        case (i_rsp_size)
            BYTE:    o_rdata = {{(`XLEN-8){1'b0}}, w_sh[7:0]};
            HWORD:   o_rdata = {{(`XLEN-16){1'b0}}, w_sh[15:0]};
            default: o_rdata = i_rdata;
        endcase
    end

endmodule

// File: rtl/dmem_resp_unit.sv
// Data-memory responder: accepts load/store commands, drives a synchronous
// single-port RAM and returns one response strobe per command.
// Optional feature macro: DMEM_MISALIGN_CHK_EN (reject misaligned accesses
// with an immediate error response instead of a truncated RAM access).
module dmem_resp_unit
    import pqr5_core_pkg::*;
#(
    parameter int ADDR_W = 12,
    parameter int RD_LAT = 1
)(
    input  logic               clk,
    input  logic               aresetn,
    input  logic               i_mem_cmd,
    input  logic [`XLEN-1:0]   i_mem_addr,
    input  logic [1:0]         i_mem_size,
    input  logic [`XLEN-1:0]   i_mem_data,
    input  logic               i_bubble,
    output logic               o_stall,
    output logic               o_ram_en,
    output logic [3:0]         o_ram_we,
    output logic [ADDR_W-1:0]  o_ram_addr,
    output logic [`XLEN-1:0]   o_ram_wdata,
    input  logic [`XLEN-1:0]   i_ram_rdata,
    output logic               o_rsp_valid,
    output logic               o_rsp_is_load,
    output logic [`XLEN-1:0]   o_rsp_data,
    output logic               o_misalign_err
);

    localparam int              CNT_W    = $clog2(RD_LAT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(RD_LAT);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    dmem_resp_state_e   r_state;
    dmem_resp_state_e   w_next_state;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_is_load;
    logic [1:0]         r_size;
    logic [1:0]         r_off;

    logic               r_stall;
    logic               r_ram_en;
    logic [3:0]         r_ram_we;
    logic [ADDR_W-1:0]  r_ram_addr;
    logic [`XLEN-1:0]   r_ram_wdata;
    logic               r_rsp_valid;
    logic               r_rsp_is_load;
    logic [`XLEN-1:0]   r_rsp_data;
    logic               r_misalign_err;

    logic               w_accept;
    logic               w_misalign;
    logic               w_last_wait;
    logic [3:0]         w_be;
    logic [`XLEN-1:0]   w_rd_aligned;
    logic               w_addr_unused;

    // Byte address bits above the RAM word address wrap and are not decoded
    assign w_addr_unused = ^i_mem_addr[`XLEN-1:ADDR_W+2];

    assign w_accept    = (r_state == IDLE) && !i_bubble;
    assign w_last_wait = (r_state == WAIT) && (r_cnt == CNT_LAST);

`ifdef DMEM_MISALIGN_CHK_EN
    assign w_misalign = is_misaligned(i_mem_size, i_mem_addr[1:0]);
`else
    assign w_misalign = 1'b0;
`endif

    dmem_lane_align u_lane_align (
        .i_cmd_size (i_mem_size),
        .i_cmd_off  (i_mem_addr[1:0]),
        .i_rsp_size (r_size),
        .i_rsp_off  (r_off),
        .i_rdata    (i_ram_rdata),
        .o_be       (w_be),
        .o_rdata    (w_rd_aligned)
    );

    // FSM state register
    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state decode; a misaligned command is answered without leaving IDLE
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE: begin
                if (w_accept && !w_misalign) begin
                    w_next_state = ACCESS;
                end else begin
                    w_next_state = IDLE;
                end
            end
            ACCESS: begin
                if (r_is_load) begin
                    w_next_state = WAIT;
                end else begin
                    w_next_state = IDLE;
                end
            end
            WAIT: begin
                if (w_last_wait) begin
                    w_next_state = IDLE;
                end else begin
                    w_next_state = WAIT;
                end
            end
            default: w_next_state = IDLE;
        endcase
    end

    // Command capture, RAM drive, read-latency counter and response registers
    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            r_cnt          <= '0;
            r_is_load      <= 1'b0;
            r_size         <= 2'b00;
            r_off          <= 2'b00;
            r_stall        <= 1'b0;
            r_ram_en       <= 1'b0;
            r_ram_we       <= 4'b0000;
            r_ram_addr     <= '0;
            r_ram_wdata    <= '0;
            r_rsp_valid    <= 1'b0;
            r_rsp_is_load  <= 1'b0;
            r_rsp_data     <= '0;
            r_misalign_err <= 1'b0;
        end else begin
            r_stall        <= (w_next_state != IDLE);
            r_ram_en       <= 1'b0;
            r_ram_we       <= 4'b0000;
            r_rsp_valid    <= 1'b0;
            r_misalign_err <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_is_load <= (i_mem_cmd == LOAD);
                        r_size    <= i_mem_size;
                        r_off     <= i_mem_addr[1:0];
                        if (w_misalign) begin
                            r_rsp_valid    <= 1'b1;
                            r_misalign_err <= 1'b1;
                            r_rsp_is_load  <= (i_mem_cmd == LOAD);
                            r_rsp_data     <= '0;
                        end else begin
                            r_ram_en    <= 1'b1;
                            r_ram_we    <= (i_mem_cmd == LOAD) ? 4'b0000 : w_be;
                            r_ram_addr  <= i_mem_addr[ADDR_W+1:2];
                            r_ram_wdata <= i_mem_data;
                        end
                    end
                end
                ACCESS: begin
                    r_cnt <= CNT_ONE;
                    if (!r_is_load) begin
                        r_rsp_valid   <= 1'b1;
                        r_rsp_is_load <= 1'b0;
                        r_rsp_data    <= '0;
                    end
                end
                WAIT: begin
                    if (w_last_wait) begin
                        r_rsp_valid   <= 1'b1;
                        r_rsp_is_load <= 1'b1;
                        r_rsp_data    <= w_rd_aligned;
                    end else begin
                        r_cnt <= r_cnt + CNT_ONE;
                    end
                end
                default: begin
                    r_cnt <= '0;
                end
            endcase
        end
    end

    assign o_stall        = r_stall;
    assign o_ram_en       = r_ram_en;
    assign o_ram_we       = r_ram_we;
    assign o_ram_addr     = r_ram_addr;
    assign o_ram_wdata    = r_ram_wdata;
    assign o_rsp_valid    = r_rsp_valid;
    assign o_rsp_is_load  = r_rsp_is_load;
    assign o_rsp_data     = r_rsp_data;
    assign o_misalign_err = r_misalign_err;

endmodule

// File: tb/tb_dmem_resp_unit.sv
// Directed bench for dmem_resp_unit: one instance with RD_LAT=1 and one
// with RD_LAT=3, each backed by a small behavioural RAM with that latency.
module tb_dmem_resp_unit;

    logic        clk = 1'b0;
    logic        aresetn;
    logic        cmd;
    logic [31:0] addr;
    logic [1:0]  size;
    logic [31:0] data;
    logic        bub1, bub3;

    logic        stall1, en1, rv1, isl1, mis1;
    logic [3:0]  we1;
    logic [11:0] ra1;
    logic [31:0] wd1, rd1, rsp1;
    logic        stall3, en3, rv3, isl3, mis3;
    logic [3:0]  we3;
    logic [11:0] ra3;
    logic [31:0] wd3, rd3, rsp3;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    dmem_resp_unit #(.ADDR_W(12), .RD_LAT(1)) u_dut1 (
        .clk(clk), .aresetn(aresetn), .i_mem_cmd(cmd), .i_mem_addr(addr),
        .i_mem_size(size), .i_mem_data(data), .i_bubble(bub1), .o_stall(stall1),
        .o_ram_en(en1), .o_ram_we(we1), .o_ram_addr(ra1), .o_ram_wdata(wd1),
        .i_ram_rdata(rd1), .o_rsp_valid(rv1), .o_rsp_is_load(isl1),
        .o_rsp_data(rsp1), .o_misalign_err(mis1)
    );

    dmem_resp_unit #(.ADDR_W(12), .RD_LAT(3)) u_dut3 (
        .clk(clk), .aresetn(aresetn), .i_mem_cmd(cmd), .i_mem_addr(addr),
        .i_mem_size(size), .i_mem_data(data), .i_bubble(bub3), .o_stall(stall3),
        .o_ram_en(en3), .o_ram_we(we3), .o_ram_addr(ra3), .o_ram_wdata(wd3),
        .i_ram_rdata(rd3), .o_rsp_valid(rv3), .o_rsp_is_load(isl3),
        .o_rsp_data(rsp3), .o_misalign_err(mis3)
    );

    // Behavioural RAM, latency 1: read data only valid for the cycle after a read
    logic [31:0] mem1 [0:4095];
    always @(posedge clk) begin
        if (en1) begin
            for (int b = 0; b < 4; b++) begin
                if (we1[b]) mem1[ra1][8*b +: 8] <= wd1[8*b +: 8];
            end
        end
        rd1 <= (en1 && we1 == 4'b0000) ? mem1[ra1] : 32'h0;
    end

    // Behavioural RAM, latency 3: three-stage read pipeline, zero when idle
    logic [31:0] mem3 [0:4095];
    logic [31:0] p3 [0:2];
    always @(posedge clk) begin
        if (en3) begin
            for (int b = 0; b < 4; b++) begin
                if (we3[b]) mem3[ra3][8*b +: 8] <= wd3[8*b +: 8];
            end
        end
        p3[0] <= (en3 && we3 == 4'b0000) ? mem3[ra3] : 32'h0;
        p3[1] <= p3[0];
        p3[2] <= p3[1];
    end
    assign rd3 = p3[2];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_cmd(input logic c, input logic [1:0] s, input logic [31:0] a, input logic [31:0] d);
        cmd  = c;
        size = s;
        addr = a;
        data = d;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        aresetn = 1'b0;
        bub1 = 1'b1;
        bub3 = 1'b1;
        set_cmd(1'b0, 2'd0, 32'h0, 32'h0);
        repeat (3) @(posedge clk);
        #1;
        // reset values
        check_eq("rst_stall", 32'(stall1), 32'd0);
        check_eq("rst_en", 32'(en1), 32'd0);
        check_eq("rst_we", 32'(we1), 32'd0);
        check_eq("rst_addr", 32'(ra1), 32'd0);
        check_eq("rst_wdata", wd1, 32'd0);
        check_eq("rst_rv", 32'(rv1), 32'd0);
        check_eq("rst_isl", 32'(isl1), 32'd0);
        check_eq("rst_data", rsp1, 32'd0);
        check_eq("rst_mis", 32'(mis1), 32'd0);
        check_eq("rst_stall3", 32'(stall3), 32'd0);
        aresetn = 1'b1;
        tick();

        // store WORD 0x10 / 0xDEADBEEF
        set_cmd(1'b1, 2'd2, 32'h10, 32'hDEADBEEF);
        bub1 = 1'b0;
        tick();
        bub1 = 1'b0;
        bub1 = 1'b1;
        check_eq("stw_en", 32'(en1), 32'd1);
        check_eq("stw_we", 32'(we1), 32'hF);
        check_eq("stw_addr", 32'(ra1), 32'd4);
        check_eq("stw_wdata", wd1, 32'hDEADBEEF);
        check_eq("stw_stall1", 32'(stall1), 32'd1);
        check_eq("stw_rv1", 32'(rv1), 32'd0);
        tick();
        check_eq("stw_rv2", 32'(rv1), 32'd1);
        check_eq("stw_isl2", 32'(isl1), 32'd0);
        check_eq("stw_data2", rsp1, 32'd0);
        check_eq("stw_stall2", 32'(stall1), 32'd0);
        check_eq("stw_en2", 32'(en1), 32'd0);

        // store BYTE 0x13 / 0xAB000000 then load it back
        set_cmd(1'b1, 2'd0, 32'h13, 32'hAB000000);
        bub1 = 1'b0;
        tick();
        bub1 = 1'b1;
        check_eq("stb_we", 32'(we1), 32'h8);
        check_eq("stb_addr", 32'(ra1), 32'd4);
        tick();
        check_eq("stb_rv", 32'(rv1), 32'd1);
        set_cmd(1'b0, 2'd0, 32'h13, 32'h0);
        bub1 = 1'b0;
        tick();
        bub1 = 1'b1;
        check_eq("ldb_en", 32'(en1), 32'd1);
        check_eq("ldb_we", 32'(we1), 32'd0);
        check_eq("ldb_stall1", 32'(stall1), 32'd1);
        tick();
        check_eq("ldb_stall2", 32'(stall1), 32'd1);
        check_eq("ldb_rv2", 32'(rv1), 32'd0);
        tick();
        check_eq("ldb_rv3", 32'(rv1), 32'd1);
        check_eq("ldb_isl3", 32'(isl1), 32'd1);
        check_eq("ldb_data3", rsp1, 32'h000000AB);
        check_eq("ldb_stall3", 32'(stall1), 32'd0);
        tick();
        check_eq("ldb_rv4", 32'(rv1), 32'd0);
        check_eq("ldb_hold4", rsp1, 32'h000000AB);

        // back-to-back: load WORD 0x10, store HWORD 0x22 in the load's response cycle
        set_cmd(1'b0, 2'd2, 32'h10, 32'h0);
        bub1 = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            tick();
            check_eq($sformatf("b2b_en%0d", k), 32'(en1), (k == 1 || k == 4) ? 32'd1 : 32'd0);
            check_eq($sformatf("b2b_stall%0d", k), 32'(stall1), (k == 1 || k == 2 || k == 4) ? 32'd1 : 32'd0);
            check_eq($sformatf("b2b_rv%0d", k), 32'(rv1), (k == 3 || k == 5) ? 32'd1 : 32'd0);
            if (k == 1) check_eq("b2b_we1", 32'(we1), 32'd0);
            if (k == 3) begin
                check_eq("b2b_ld_data", rsp1, 32'hABADBEEF);
                check_eq("b2b_ld_isl", 32'(isl1), 32'd1);
                set_cmd(1'b1, 2'd1, 32'h22, 32'h5A5A0000);
            end
            if (k == 4) begin
                bub1 = 1'b1;
                check_eq("b2b_st_we", 32'(we1), 32'hC);
                check_eq("b2b_st_addr", 32'(ra1), 32'd8);
                check_eq("b2b_st_wdata", wd1, 32'h5A5A0000);
            end
            if (k == 5) check_eq("b2b_st_isl", 32'(isl1), 32'd0);
        end
        // bubbles with junk command fields produce nothing
        set_cmd(1'b1, 2'd2, 32'h44, 32'hFFFFFFFF);
        for (int k = 1; k <= 3; k++) begin
            tick();
            check_eq($sformatf("bub_en%0d", k), 32'(en1), 32'd0);
            check_eq($sformatf("bub_rv%0d", k), 32'(rv1), 32'd0);
            check_eq($sformatf("bub_stall%0d", k), 32'(stall1), 32'd0);
        end

        // RD_LAT=3: preload word 8 with a store, then load HWORD 0x22
        set_cmd(1'b1, 2'd2, 32'h20, 32'h12345678);
        bub3 = 1'b0;
        tick();
        bub3 = 1'b1;
        check_eq("l3_st_en", 32'(en3), 32'd1);
        check_eq("l3_st_addr", 32'(ra3), 32'd8);
        tick();
        check_eq("l3_st_rv", 32'(rv3), 32'd1);
        set_cmd(1'b0, 2'd1, 32'h22, 32'h0);
        bub3 = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            tick();
            if (k == 1) bub3 = 1'b1;
            check_eq($sformatf("l3_stall%0d", k), 32'(stall3), (k <= 4) ? 32'd1 : 32'd0);
            check_eq($sformatf("l3_rv%0d", k), 32'(rv3), (k == 5) ? 32'd1 : 32'd0);
            if (k == 5) begin
                check_eq("l3_data", rsp3, 32'h00001234);
                check_eq("l3_isl", 32'(isl3), 32'd1);
            end
        end

        // reset during WAIT abandons the load
        set_cmd(1'b0, 2'd2, 32'h20, 32'h0);
        bub3 = 1'b0;
        tick();
        bub3 = 1'b1;
        tick();
        check_eq("rw_pre_stall", 32'(stall3), 32'd1);
        aresetn = 1'b0;
        #1;
        check_eq("rw_stall", 32'(stall3), 32'd0);
        check_eq("rw_rv", 32'(rv3), 32'd0);
        check_eq("rw_en", 32'(en3), 32'd0);
        check_eq("rw_data", rsp3, 32'd0);
        check_eq("rw_addr", 32'(ra3), 32'd0);
        tick();
        tick();
        aresetn = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            tick();
            check_eq($sformatf("rw_no_rv%0d", k), 32'(rv3), 32'd0);
        end
        bub3 = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            tick();
            if (k == 1) bub3 = 1'b1;
            if (k == 5) begin
                check_eq("rw_ld_rv", 32'(rv3), 32'd1);
                check_eq("rw_ld_data", rsp3, 32'h12345678);
            end
        end

        // misaligned WORD store at 0x06
        set_cmd(1'b1, 2'd2, 32'h06, 32'h11223344);
        bub1 = 1'b0;
        tick();
        bub1 = 1'b1;
`ifdef DMEM_MISALIGN_CHK_EN
        check_eq("mis_en", 32'(en1), 32'd0);
        check_eq("mis_we", 32'(we1), 32'd0);
        check_eq("mis_err", 32'(mis1), 32'd1);
        check_eq("mis_rv", 32'(rv1), 32'd1);
        check_eq("mis_isl", 32'(isl1), 32'd0);
        check_eq("mis_data", rsp1, 32'd0);
        check_eq("mis_stall", 32'(stall1), 32'd0);
        tick();
        check_eq("mis_err2", 32'(mis1), 32'd0);
        check_eq("mis_rv2", 32'(rv1), 32'd0);
        check_eq("mis_stall2", 32'(stall1), 32'd0);
`else
        check_eq("mis_en", 32'(en1), 32'd1);
        check_eq("mis_we", 32'(we1), 32'hF);
        check_eq("mis_addr", 32'(ra1), 32'd1);
        check_eq("mis_err", 32'(mis1), 32'd0);
        check_eq("mis_stall", 32'(stall1), 32'd1);
        tick();
        check_eq("mis_rv2", 32'(rv1), 32'd1);
        check_eq("mis_err2", 32'(mis1), 32'd0);
`endif

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/dmem_resp_unit.md
Name: dmem_resp_unit

Overview:
- Responder end of the EXU memory access interface. Accepts Load/Store commands (cmd/addr/size/data/bubble) from the load-store unit and drives a synchronous single-port data RAM with byte enables.
- For loads, waits a configurable read latency, then returns right-aligned, zero-extended read data. Sign extension is performed downstream.
- Back-pressures the pipeline with o_stall while an access is in flight.

Parameters:
- ADDR_W, 12, word-address width of the RAM port; byte address bits [ADDR_W+1:2] are used, upper bits ignored (wrap).
- RD_LAT, 1, RAM read latency in cycles from the sampled o_ram_en to valid i_ram_rdata; legal range 1..4.

Ports:
- clk  in  1  clock
- aresetn  in  1  asynchronous reset, active-low
- i_mem_cmd  in  1  0 = Load, 1 = Store
- i_mem_addr  in  `XLEN  byte address
- i_mem_size  in  2  0 = BYTE, 1 = HWORD, 2 = WORD, 3 treated as WORD
- i_mem_data  in  `XLEN  store data, already lane-shifted by the initiator
- i_bubble  in  1  1 = no command this cycle
- o_stall  out  1  1 = command not accepted; initiator holds its outputs
- o_ram_en  out  1  RAM access enable
- o_ram_we  out  4  byte write enables
- o_ram_addr  out  ADDR_W  word address
- o_ram_wdata  out  `XLEN  write data
- i_ram_rdata  in  `XLEN  RAM read data
- o_rsp_valid  out  1  one-cycle response strobe
- o_rsp_is_load  out  1  response belongs to a load
- o_rsp_data  out  `XLEN  load data, right-aligned, zero-extended; 0 for stores
- o_misalign_err  out  1  misalignment pulse; tied 0 when the optional feature is off

Behaviour:
- All outputs are registered. Reset values:
  - state = IDLE
  - o_stall = 0, o_ram_en = 0, o_ram_we = 0, o_ram_addr = 0, o_ram_wdata = 0
  - o_rsp_valid = 0, o_rsp_is_load = 0, o_rsp_data = 0, o_misalign_err = 0
- Accept rule: a command is accepted in cycle T iff state == IDLE and i_bubble == 0. o_stall = (state != IDLE), decoded from registered state.
- FSM states: IDLE, ACCESS, WAIT.
  - IDLE -> ACCESS on accept. Register the command and drive o_ram_en = 1, o_ram_addr, o_ram_we, o_ram_wdata during T+1.
  - ACCESS, store -> IDLE. o_rsp_valid = 1, is_load = 0, data = 0 in T+2.
  - ACCESS, load -> WAIT. o_ram_en = 0 and o_ram_we = 0 outside ACCESS.
  - WAIT counts RD_LAT cycles with a clog2(RD_LAT+1) counter. On the last WAIT cycle, capture the aligned i_ram_rdata, then -> IDLE. o_rsp_valid = 1, is_load = 1 in that next cycle.
- Latency and stall windows:
  - Store: response at T+2; stall high in T+1.
  - Load: response at T+2+RD_LAT; stall high T+1 .. T+1+RD_LAT.
  - A new command may be accepted in the same cycle o_rsp_valid is high.
- Byte enables, with off = addr[1:0]:
  - BYTE: 4'b0001 << off
  - HWORD: (4'b0011 << off), truncated to 4 bits
  - WORD: 4'b1111
  - Loads: o_ram_we = 0.
- Read extract: sh = rdata >> (8*off).
  - BYTE: {24'b0, sh[7:0]}
  - HWORD: {16'b0, sh[15:0]}
  - WORD: rdata unshifted; address forced aligned.
- Response fields hold their value between strobes. o_rsp_valid and o_misalign_err are single-cycle pulses.
- Reset mid-operation: in-flight access is abandoned, no response is issued, and all registers take reset values.
- i_mem_* are ignored while o_stall = 1 and while i_bubble = 1.

Optional Feature:
- Macro: DMEM_MISALIGN_CHK_EN
- Defined:
  - A misaligned command is accepted but issues no RAM access. Misaligned means HWORD with addr[0] = 1, or WORD with addr[1:0] != 0.
  - In T+1: o_misalign_err = 1, o_rsp_valid = 1, o_rsp_is_load = cmd==Load, o_rsp_data = 0.
  - State stays IDLE and no stall is raised.
- Undefined: no check, truncated enables as above, o_misalign_err tied 0.

Decomposition:
- pqr5_core_pkg: size constants BYTE/HWORD/WORD, LOAD/STORE command constants, and the dmem_resp state typedef enum {IDLE, ACCESS, WAIT}.
- Sub-module dmem_lane_align (combinational): generates byte enables from size/off and extracts read data.
- FSM, counter and registers stay in dmem_resp_unit.

Test Plan:
- Store WORD, addr 0x0000_0010, data 0xDEADBEEF -> T+1: en = 1, we = 4'b1111, ram_addr = 4, wdata = 0xDEADBEEF; T+2: rsp_valid = 1, is_load = 0; stall high only in T+1.
- Store BYTE, addr 0x13, data 0xAB00_0000 -> we = 4'b1000, ram_addr = 4; follow with load BYTE, addr 0x13, RAM word 0xAB00_0000 -> rsp_data = 0x0000_00AB at T+3 (RD_LAT = 1).
- Load HWORD, addr 0x22, RAM word 0x1234_5678, RD_LAT = 3 -> stall high T+1..T+4; rsp_valid at T+5 with 0x0000_1234.
- Back-to-back: load then store with i_bubble held 0 -> store accepted in the load's rsp_valid cycle; no command lost or duplicated; i_bubble = 1 cycles produce no en.
- aresetn low during WAIT -> all outputs 0 immediately, no rsp_valid after release, next load completes normally.
- With DMEM_MISALIGN_CHK_EN: store WORD, addr 0x06 -> no en/we, T+1 misalign_err = 1, rsp_valid = 1, stall never asserted. Without the macro: same stimulus -> we = 4'b1111, ram_addr = 1, misalign_err = 0.
